// File: rtl/rdback_pkg.sv
// rdback_pkg: shared constants and slice helpers for the multi-PC read-back buffer
package rdback_pkg;
  localparam int OVF_W = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction
endpackage

// File: rtl/rdback_pc_lane.sv
// rdback_pc_lane: per-pseudo-channel beat assembler, first-word-fall-through FIFO and saturating overflow counter
module rdback_pc_lane import rdback_pkg::*; #(
  parameter int LANE_W = 128,
  parameter int BEATS = 2,
  parameter int DEPTH = 512,
  localparam int ENTRY_W = LANE_W * BEATS,
  localparam int FW = clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LANE_W-1:0]  p0,
  input  logic [LANE_W-1:0]  p1,
  input  logic               v0,
  input  logic               v1,
  input  logic               flush,
  input  logic               clr_stats,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               empty,
  output logic [FW-1:0]      fill,
  output logic [OVF_W-1:0]   ovf_cnt
);
  localparam int CW = clog2(BEATS);
  localparam int AW = clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
  logic [CW-1:0] cnt, cnt_n;
  logic [ENTRY_W-1:0] asm_q, asm_n, ent;
  logic push, pop, acc, drop;
  logic [AW-1:0] wp, rp, rp_n;
  logic [ENTRY_W-1:0] mem [DEPTH];
  always_comb begin
    asm_n = asm_q;
    cnt_n = cnt;
    push = 1'b0;
    ent = asm_q;
    if (v0 | v1) begin
      asm_n[cnt_n*LANE_W +: LANE_W] = v0 ? p0 : p1;
      push = cnt_n == LAST;
      ent = asm_n;
      cnt_n = cnt_n + 1'b1;
    end
    if (v0 & v1) begin
      asm_n[cnt_n*LANE_W +: LANE_W] = p1;
      ent = (cnt_n == LAST) ? asm_n : ent;
      push = push | (cnt_n == LAST);
      cnt_n = cnt_n + 1'b1;
    end
  end
  assign empty = fill == '0;
  assign pop = rd_en & ~empty & ~flush;
  assign acc = push & ~flush & ((fill != FW'(DEPTH)) | pop);
  assign drop = push & ~flush & ~acc;
  assign rp_n = flush ? '0 : rp + AW'(pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      fill <= '0;
      ovf_cnt <= '0;
    end else begin
      cnt <= flush ? '0 : cnt_n;
      wp <= flush ? '0 : wp + AW'(acc);
      rp <= rp_n;
      fill <= flush ? '0 : fill + FW'(acc) - FW'(pop);
      ovf_cnt <= clr_stats ? '0 : ovf_cnt + OVF_W'(drop & ~&ovf_cnt);
    end
  end
  // head register reads the next read address, bypassing a write to that same slot
  always_ff @(posedge clk) begin
    if (acc) mem[wp] <= ent;
    asm_q <= asm_n;
    rd_data <= (acc && wp == rp_n) ? ent : mem[rp_n];
  end
endmodule

// File: rtl/multi_pc_rdback.sv
// multi_pc_rdback: NUM_PC-channel DFI read capture and read-back buffer with almost-full clock-disable throttle
module multi_pc_rdback import rdback_pkg::*; #(
  parameter int NUM_PC = 2,
  parameter int LANE_W = 128,
  parameter int BEATS = 2,
  parameter int DEPTH = 512,
  parameter int AFULL_MARGIN = 16,
  localparam int ENTRY_W = LANE_W * BEATS,
  localparam int FW = clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_PC*LANE_W-1:0]  dfi_rddata_p0,
  input  logic [NUM_PC*LANE_W-1:0]  dfi_rddata_p1,
  input  logic [2*NUM_PC-1:0]       dfi_rddata_valid,
  input  logic                      flush,
  input  logic                      clr_stats,
  input  logic [NUM_PC-1:0]         rd_en,
  output logic [NUM_PC*ENTRY_W-1:0] rd_data,
  output logic [NUM_PC-1:0]         empty,
  output logic [NUM_PC*FW-1:0]      fill,
  output logic [NUM_PC*OVF_W-1:0]   ovf_cnt,
  output logic                      ck_dis
);
  logic [NUM_PC-1:0] over;
  for (genvar k = 0; k < NUM_PC; k++) begin : g_pc
    rdback_pc_lane #(.LANE_W(LANE_W), .BEATS(BEATS), .DEPTH(DEPTH)) u_lane (
      .clk(clk),
      .rst(rst),
      .p0(dfi_rddata_p0[lane_lo(k, LANE_W) +: LANE_W]),
      .p1(dfi_rddata_p1[lane_lo(k, LANE_W) +: LANE_W]),
      .v0(dfi_rddata_valid[2*k]),
      .v1(dfi_rddata_valid[2*k+1]),
      .flush(flush),
      .clr_stats(clr_stats),
      .rd_en(rd_en[k]),
      .rd_data(rd_data[lane_lo(k, ENTRY_W) +: ENTRY_W]),
      .empty(empty[k]),
      .fill(fill[lane_lo(k, FW) +: FW]),
      .ovf_cnt(ovf_cnt[lane_lo(k, OVF_W) +: OVF_W])
    );
    assign over[k] = fill[lane_lo(k, FW) +: FW] >= FW'(DEPTH - AFULL_MARGIN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ck_dis <= 1'b0;
    else ck_dis <= |over;
  end
endmodule

// File: doc/multi_pc_rdback.md
# multi_pc_rdback

Parametrised read-capture and read-back buffer for the SoftMC HBM2 datapath. It sits between the PHY DFI read-data return and the host read-back interface. It generalises the fixed two-pseudo-channel capturer and FIFO pair to NUM_PC pseudo-channels, with:
- configurable beat packing;
- an almost-full clock-disable throttle;
- per-channel occupancy reporting;
- saturating overflow statistics.

## Interface
Parameters:
- NUM_PC, 2, number of pseudo-channels (1..8)
- LANE_W, 128, DFI read-data bits per pseudo-channel per phase
- BEATS, 2, beats packed into one FIFO entry; power of two, 2..8
- DEPTH, 512, entries per channel FIFO; power of two, ≥16
- AFULL_MARGIN, 16, ck_dis asserts when any fill ≥ DEPTH−AFULL_MARGIN; must be 4..DEPTH/2

Derived values:
- ENTRY_W = LANE_W*BEATS
- FW = clog2(DEPTH)+1

Ports:
- clk  in  1  sole clock
- rst  in  1  asynchronous, active-high reset
- dfi_rddata_p0  in  NUM_PC*LANE_W  phase-0 data; lane k = bits [k*LANE_W +: LANE_W]
- dfi_rddata_p1  in  NUM_PC*LANE_W  phase-1 data, same lane map
- dfi_rddata_valid  in  2*NUM_PC  bit 2k = p0 valid of PC k, bit 2k+1 = p1 valid of PC k
- flush  in  1  synchronous clear of all assemblers and FIFOs
- clr_stats  in  1  synchronous clear of all overflow counters
- rd_en  in  NUM_PC  pop request per PC
- rd_data  out  NUM_PC*ENTRY_W  head entry per PC (first-word fall-through)
- empty  out  NUM_PC  FIFO empty per PC
- fill  out  NUM_PC*FW  FIFO occupancy per PC
- ovf_cnt  out  NUM_PC*16  dropped-entry count per PC, saturating
- ck_dis  out  1  throttle to the dispatcher/PHY (drives dfi_0_aw_ck_dis)

## Operation
Assembler (per PC):
- Beat counter runs 0..BEATS−1. In one cycle, a valid p0 beat is taken before a valid p1 beat.
- A p1 beat without p0 is accepted as a single beat.
- Beat i of an entry lands in bits [i*LANE_W +: LANE_W], so the first beat is in the LSBs.
- When the counter wraps, the entry is pushed. Because BEATS ≥ 2, there is at most one push per PC per cycle.
- If p0 completes an entry, p1 in the same cycle becomes beat 0 of the next entry.

FIFO (per PC):
- Push is accepted if fill < DEPTH, or if fill = DEPTH and rd_en pops in the same cycle.
- Otherwise the entry is dropped, ovf_cnt increments (saturating at 16'hFFFF), and FIFO contents are unchanged.
- rd_en while empty is ignored.
- Simultaneous push and pop leaves fill unchanged.

ck_dis:
- Registered OR over PCs of (fill ≥ DEPTH−AFULL_MARGIN).
- Deasserts once every fill is below the threshold; there is no hysteresis.

flush:
- Zeroes beat counters, FIFO pointers and fill; empty goes to all ones.
- Beats arriving in the flush cycle are discarded.
- ovf_cnt is untouched.

clr_stats:
- Zeroes ovf_cnt.
- If an overflow coincides with clr_stats, the result is 0.

Reset values: empty all ones; fill 0; ovf_cnt 0; ck_dis 0; rd_data don't-care while empty. Assemblers are cleared.

## Timing
- A beat completing an entry at edge N gives empty low, rd_data valid and fill+1 after N+1.
- ck_dis reflects the new fill after N+2.
- A pop at edge N shows the next head on rd_data and fill−1 after N+1.
- Throughput per PC: two beats per cycle sustained.
- Full-rate push/pop at fill = DEPTH runs lossless.
- Asynchronous reset in mid-entry discards the partial entry. Operation resumes on the first edge after rst falls.

## Structure
- Package rdback_pkg holds:
  - clog2 function;
  - OVF_W = 16 constant;
  - lane/entry slice helper functions.
- Sub-module rdback_pc_lane contains the assembler, the FIFO (inferred block RAM with registered pointers) and the overflow counter. It is instantiated NUM_PC times under generate.
- The top level holds only lane slicing and the ck_dis reduction register.

## Test plan
- Reset, then on PC0 p0 = A, p1 = B in one cycle (BEATS = 2) -> one entry {B,A}; empty[0] low one cycle later; fill[0] = 1; PC1 untouched.
- BEATS = 4, PC1 p1-only beats 1,2,3,4 over four cycles -> single entry {4,3,2,1} after the fourth.
- Fill PC0 to DEPTH−AFULL_MARGIN (496) with no pops -> ck_dis high two cycles after the 496th push; pop one entry -> ck_dis low one cycle after fill reaches 495.
- PC0 full (512), push 3 more with no pop -> ovf_cnt[0] = 3, fill stays 512, head data unchanged; push with simultaneous pop at full -> ovf unchanged, fill 512.
- ovf_cnt preloaded to 16'hFFFF via 65535 drops, one more drop -> stays 16'hFFFF; clr_stats with coincident drop -> 0.
- Partial entry (1 of 2 beats) then flush -> next beats form a fresh entry from beat 0; ovf_cnt retained. Repeat with asynchronous rst mid-entry -> all outputs at reset values immediately.
